uart_rx: RTL and testbench

- 8N1 UART receiver, the receive-side counterpart of the team's 16x-oversampled transmitter.
- Runs directly on the oversample clock: one clk = one sample tick, so one bit = OVERSAMPLE clocks.
- Synchronises the serial line, validates the start bit, majority-votes each bit at mid-cell, checks the stop bit, and presents the byte with a one-cycle valid strobe.
- Sits between the board RX pin and the command/display logic.

---
 rtl/uart_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_rx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver clocked at the oversample rate. It synchronises the line, validates the
// start bit, majority-votes each bit at mid-cell, checks the stop bit and strobes out the byte.
`timescale 1ns/1ps

module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_in,
    output logic [7:0] data_received,
    output logic       valid,
    output logic       received,
    output logic       frame_err,
    output logic       busy
);

    localparam int MID = OVERSAMPLE / 2;
    localparam int CW  = $clog2(OVERSAMPLE);

    localparam logic [CW-1:0] C_VOTE0  = CW'(MID - 1);
    localparam logic [CW-1:0] C_VOTE1  = CW'(MID);
    localparam logic [CW-1:0] C_DECIDE = CW'(MID + 1);
    localparam logic [CW-1:0] C_LAST   = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          v0_q, v0_d;
    logic          v1_q, v1_d;
    logic          sync1, sync2;
    logic          rx_s;
    logic          vote;

    // Synchroniser flops reset high so an idle line is not mistaken for a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value, giving a true 2-stage chain.
            sync1 <= bit_in;
            sync2 <= sync1;
        end
    end

    assign rx_s = sync2;

    // The third vote sample is the live rx_s at the decision cycle.
    assign vote = (v0_q & v1_q) | (v0_q & rx_s) | (v1_q & rx_s);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        v0_d    = v0_q;
        v1_d    = v1_q;

        if (cnt_q == C_VOTE0) v0_d = rx_s;
        if (cnt_q == C_VOTE1) v1_d = rx_s;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = CW'(1);
                end
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_DECIDE && vote) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == C_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_DECIDE) shreg_d = {vote, shreg_q[7:1]};
                if (cnt_q == C_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_DECIDE) begin
                    cnt_d = '0;
                    if (vote) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            v0_q    <= 1'b1;
            v1_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
        end
    end

    assign data_received = data_q;
    assign valid         = valid_q;
    assign frame_err     = ferr_q;
    assign busy          = (state_q != IDLE);
    assign received      = !(state_q == START || state_q == DATA || state_q == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean frames, glitch rejection, framing errors, back-to-back
// frames, break, asynchronous reset mid-frame and loopback from a simple transmitter model.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       drv_line;
    logic       use_tx;
    wire        bit_in;
    logic [7:0] data_received;
    logic       valid;
    logic       received;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk           (clk),
        .reset         (reset),
        .bit_in        (bit_in),
        .data_received (data_received),
        .valid         (valid),
        .received      (received),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Transmitter model: an ena pulse latches data into temp and shifts out start, 8 data LSB first, stop.
    logic       tx_ena  = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] tx_temp = 8'h00;
    logic [9:0] tx_sh   = 10'h3FF;
    int         tx_left = 0;
    int         tx_tick = 0;
    wire        tx_line = (tx_left != 0) ? tx_sh[0] : 1'b1;

    always @(posedge clk) begin
        if (tx_ena && tx_left == 0) begin
            tx_sh   <= {1'b1, tx_data, 1'b0};
            tx_temp <= tx_data;
            tx_left <= 10;
            tx_tick <= 0;
        end else if (tx_left != 0) begin
            if (tx_tick == OS - 1) begin
                tx_tick <= 0;
                tx_sh   <= {1'b1, tx_sh[9:1]};
                tx_left <= tx_left - 1;
            end else begin
                tx_tick <= tx_tick + 1;
            end
        end
    end

    assign bit_in = use_tx ? tx_line : drv_line;

    // Output monitor, sampled on the inactive edge.
    int         valid_total = 0;
    int         ferr_total  = 0;
    int         both_total  = 0;
    int         long_total  = 0;
    int         recv_low    = 0;
    logic       valid_prev  = 1'b0;
    logic       ferr_prev   = 1'b0;
    logic [7:0] data_log [0:63];

    always @(negedge clk) begin
        if (!reset) begin
            if (valid) begin
                if (valid_total < 64) data_log[valid_total] = data_received;
                valid_total = valid_total + 1;
            end
            if (frame_err) ferr_total = ferr_total + 1;
            if (valid && frame_err) both_total = both_total + 1;
            if ((valid && valid_prev) || (frame_err && ferr_prev)) long_total = long_total + 1;
            if (!received) recv_low = recv_low + 1;
        end
        valid_prev = valid;
        ferr_prev  = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic line_bit(input logic b, input int clocks);
        drv_line = b;
        repeat (clocks) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        line_bit(1'b0, OS);
        for (int i = 0; i < 8; i++) line_bit(d[i], OS);
        line_bit(stop_bit, OS);
    endtask

    int v_base, f_base, r_base;
    logic busy_cleared;

    initial begin
        reset    = 1'b1;
        drv_line = 1'b1;
        use_tx   = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_data",     32'(data_received), 32'h00);
        check("reset_valid",    32'(valid),         32'h0);
        check("reset_received", 32'(received),      32'h1);
        check("reset_ferr",     32'(frame_err),     32'h0);
        check("reset_busy",     32'(busy),          32'h0);

        reset = 1'b0;
        line_bit(1'b1, 100);

        // Clean frame 0xA5.
        v_base = valid_total; f_base = ferr_total; r_base = recv_low;
        send_byte(8'hA5, 1'b1);
        line_bit(1'b1, 20);
        check("a5_valid_count", 32'(valid_total - v_base), 32'd1);
        check("a5_data",        32'(data_received),        32'hA5);
        check("a5_recv_low",    32'(recv_low > r_base),    32'h1);
        check("a5_recv_after",  32'(received),             32'h1);
        check("a5_no_ferr",     32'(ferr_total - f_base),  32'd0);
        check("a5_idle",        32'(busy),                 32'h0);

        // Three-clock glitch must be rejected as a false start.
        v_base = valid_total; f_base = ferr_total;
        line_bit(1'b0, 3);
        drv_line     = 1'b1;
        busy_cleared = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0 && !busy) busy_cleared = 1'b1;
        end
        check("glitch_busy_clear", 32'(busy_cleared),         32'h1);
        line_bit(1'b1, 20);
        check("glitch_no_valid",   32'(valid_total - v_base), 32'd0);
        check("glitch_data",       32'(data_received),        32'hA5);
        check("glitch_no_ferr",    32'(ferr_total - f_base),  32'd0);

        // Frame 0x3C with a low stop bit, then 0x11 cleanly.
        v_base = valid_total; f_base = ferr_total;
        send_byte(8'h3C, 1'b0);
        line_bit(1'b1, 20);
        check("ferr_count",    32'(ferr_total - f_base),  32'd1);
        check("ferr_no_valid", 32'(valid_total - v_base), 32'd0);
        check("ferr_data",     32'(data_received),        32'hA5);
        v_base = valid_total;
        send_byte(8'h11, 1'b1);
        line_bit(1'b1, 20);
        check("after_ferr_valid", 32'(valid_total - v_base), 32'd1);
        check("after_ferr_data",  32'(data_received),        32'h11);

        // Back-to-back 0x00 then 0xFF with no idle gap.
        v_base = valid_total;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        line_bit(1'b1, 20);
        check("b2b_count", 32'(valid_total - v_base), 32'd2);
        check("b2b_first", 32'(data_log[v_base]),     32'h00);
        check("b2b_second",32'(data_log[v_base + 1]), 32'hFF);

        // Break: line low for 400 clocks.
        v_base = valid_total; f_base = ferr_total;
        line_bit(1'b0, 400);
        check("break_ferr",     32'(ferr_total - f_base),  32'd1);
        check("break_no_valid", 32'(valid_total - v_base), 32'd0);
        check("break_busy",     32'(busy),                 32'h1);
        check("break_received", 32'(received),             32'h1);
        line_bit(1'b1, 20);
        check("break_released", 32'(busy),                 32'h0);
        v_base = valid_total;
        send_byte(8'h5A, 1'b1);
        line_bit(1'b1, 20);
        check("post_break_valid", 32'(valid_total - v_base), 32'd1);
        check("post_break_data",  32'(data_received),        32'h5A);

        // Asynchronous reset in the middle of data bit 4 of 0xC3.
        line_bit(1'b0, OS);
        for (int i = 0; i < 4; i++) line_bit(1'(8'hC3 >> i), OS);
        line_bit(1'b0, OS / 2);
        check("pre_reset_busy", 32'(busy), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("async_data",     32'(data_received), 32'h00);
        check("async_valid",    32'(valid),         32'h0);
        check("async_received", 32'(received),      32'h1);
        check("async_ferr",     32'(frame_err),     32'h0);
        check("async_busy",     32'(busy),          32'h0);
        drv_line = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        line_bit(1'b1, 20);
        v_base = valid_total;
        send_byte(8'h7E, 1'b1);
        line_bit(1'b1, 20);
        check("post_reset_valid", 32'(valid_total - v_base), 32'd1);
        check("post_reset_data",  32'(data_received),        32'h7E);

        // Loopback from the transmitter model.
        use_tx = 1'b1;
        v_base = valid_total;
        tx_data = 8'h96;
        tx_ena  = 1'b1;
        @(negedge clk);
        tx_ena  = 1'b0;
        repeat (10 * OS + 30) @(negedge clk);
        check("loop_valid", 32'(valid_total - v_base), 32'd1);
        check("loop_data",  32'(data_received),        32'h96);
        check("loop_temp",  32'(data_received),        32'(tx_temp));

        check("never_both",    32'(both_total), 32'd0);
        check("single_pulses", 32'(long_total), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
